// File: rtl/echo_delay.sv
// Stereo echo: per-channel circular delay line with feedback, wet mix and saturation.
// One sync-read RAM holds both channels at address {ch, ptr}; everything runs on bclk.
module echo_delay #(
  parameter int BITSIZE = 16,
  parameter int ADDRLEN = 14
) (
  input  logic               bclk,
  input  logic               reset,
  input  logic               lrclk,
  input  logic               enable,
  input  logic [ADDRLEN-1:0] offset,
  input  logic [8:0]         feedback,
  input  logic [8:0]         mix,
  input  logic [BITSIZE-1:0] in_l,
  input  logic [BITSIZE-1:0] in_r,
  output logic [BITSIZE-1:0] out_l,
  output logic [BITSIZE-1:0] out_r,
  output logic               busy,
  output logic               overrun
);

  if (BITSIZE != 16 && BITSIZE != 24) begin : g_bad_width
    $error("echo_delay: BITSIZE must be 16 or 24, got %0d", BITSIZE);
  end

  localparam int DEPTH = 2 ** (ADDRLEN + 1);

  typedef enum logic [2:0] {CLEAR, IDLE, RD_L, WR_L, RD_R, WR_R, ADV} state_t;

  state_t             state;
  logic [BITSIZE-1:0] mem [DEPTH];
  logic [BITSIZE-1:0] rd_data;
  logic [BITSIZE-1:0] cap_l, cap_r, wet_l, wet_r;
  logic [ADDRLEN-1:0] wr_ptr, rd_ptr;
  logic [ADDRLEN:0]   clr_addr;
  logic               lrclk_d, rise;
  logic [9:0]         fb_g, mix_g;
  logic               we;
  logic [ADDRLEN:0]   wa, ra;
  logic [BITSIZE-1:0] wd;

  // sat(x + floor(d*g/256)); g is unsigned Q1.8 already clamped to <= 256
  function automatic logic [BITSIZE-1:0] mac(input logic [BITSIZE-1:0] x,
                                             input logic [BITSIZE-1:0] d,
                                             input logic [9:0]         g);
    logic signed [BITSIZE+9:0] de, ge, p;
    logic [BITSIZE+1:0]        s;
    de = {{10{d[BITSIZE-1]}}, d};
    ge = {{BITSIZE{1'b0}}, g};
    p  = de * ge;
    p  = p >>> 8;
    s  = {{2{x[BITSIZE-1]}}, x} + p[BITSIZE+1:0];
    if ((&s[BITSIZE+1:BITSIZE-1]) || !(|s[BITSIZE+1:BITSIZE-1]))
      return s[BITSIZE-1:0];
    else if (s[BITSIZE+1])
      return {1'b1, {(BITSIZE-1){1'b0}}};
    else
      return {1'b0, {(BITSIZE-1){1'b1}}};
  endfunction

  always_comb begin
    fb_g   = (feedback > 9'd256) ? 10'd256 : {1'b0, feedback};
    mix_g  = (mix > 9'd256) ? 10'd256 : {1'b0, mix};
    rd_ptr = wr_ptr - offset;
    ra     = {state == RD_R, rd_ptr};
    we     = 1'b0;
    wa     = {1'b0, wr_ptr};
    wd     = '0;
    case (state)
      CLEAR: begin
        we = !reset;
        wa = clr_addr;
      end
      WR_L: begin
        we = !reset;
        wd = mac(cap_l, rd_data, fb_g);
      end
      WR_R: begin
        we = !reset;
        wa = {1'b1, wr_ptr};
        wd = mac(cap_r, rd_data, fb_g);
      end
      default: ;
    endcase
  end

  // Read precedes the write in a later state, so offset=0 yields the oldest frame
  always_ff @(posedge bclk) begin
    if (we) mem[wa] <= wd;
    rd_data <= mem[ra];
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state    <= CLEAR;
      busy     <= 1'b1;
      overrun  <= 1'b0;
      out_l    <= '0;
      out_r    <= '0;
      wr_ptr   <= '0;
      lrclk_d  <= 1'b0;
      rise     <= 1'b0;
      clr_addr <= '0;
      cap_l    <= '0;
      cap_r    <= '0;
      wet_l    <= '0;
      wet_r    <= '0;
    end else begin
      lrclk_d <= lrclk;
      rise    <= lrclk && !lrclk_d && (state != CLEAR);
      overrun <= rise && (state != IDLE) && (state != CLEAR);
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        IDLE: if (rise) begin
          cap_l <= in_l;
          cap_r <= in_r;
          state <= RD_L;
        end
        RD_L: state <= WR_L;
        WR_L: begin
          wet_l <= mac(cap_l, rd_data, mix_g);
          state <= RD_R;
        end
        RD_R: state <= WR_R;
        WR_R: begin
          wet_r <= mac(cap_r, rd_data, mix_g);
          state <= ADV;
        end
        ADV: begin
          wr_ptr <= wr_ptr + 1'b1;
          out_l  <= enable ? wet_l : cap_l;
          out_r  <= enable ? wet_r : cap_r;
          state  <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay.sv
// Bench for echo_delay: constant vector table, hand-built timing corners and
// randomized frames checked against a frame-level delay-line model.
module tb_echo_delay;
  localparam int BITSIZE = 16;
  localparam int ADDRLEN = 4;
  localparam int FRAMES  = 2 ** ADDRLEN;
  localparam int MAXV    = 2 ** (BITSIZE - 1) - 1;
  localparam int MINV    = -(2 ** (BITSIZE - 1));

  logic               bclk = 1'b0, reset = 1'b0, lrclk = 1'b0, enable = 1'b0;
  logic [ADDRLEN-1:0] offset = '0;
  logic [8:0]         feedback = '0, mix = '0;
  logic [BITSIZE-1:0] in_l = '0, in_r = '0;
  logic [BITSIZE-1:0] out_l, out_r;
  logic               busy, overrun;

  echo_delay #(.BITSIZE(BITSIZE), .ADDRLEN(ADDRLEN)) dut (
    .bclk(bclk), .reset(reset), .lrclk(lrclk), .enable(enable), .offset(offset),
    .feedback(feedback), .mix(mix), .in_l(in_l), .in_r(in_r),
    .out_l(out_l), .out_r(out_r), .busy(busy), .overrun(overrun)
  );

  always #5 bclk = ~bclk;

  typedef struct {
    bit rst; int grp; int il; int ir; int off; int fb; int mx; bit en; int el; int er;
  } vec_t;

  vec_t tab[$];
  int checks = 0, errors = 0;
  int line_l[FRAMES], line_r[FRAMES];
  int mptr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [BITSIZE-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floor256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int clampg(input int g);
    return (g > 256) ? 256 : g;
  endfunction

  function automatic int satv(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FRAMES; i++) begin
      line_l[i] = 0;
      line_r[i] = 0;
    end
    mptr = 0;
  endtask

  task automatic model_frame(input int il, input int ir, input int off, input int fb,
                             input int mx, input bit en, output int el, output int er);
    int rp, dl, dr;
    rp = (mptr - off + FRAMES) % FRAMES;
    dl = line_l[rp];
    dr = line_r[rp];
    line_l[mptr] = satv(il + floor256(dl * clampg(fb)));
    line_r[mptr] = satv(ir + floor256(dr * clampg(fb)));
    el = en ? satv(il + floor256(dl * clampg(mx))) : il;
    er = en ? satv(ir + floor256(dr * clampg(mx))) : ir;
    mptr = (mptr + 1) % FRAMES;
  endtask

  task automatic add(input bit rst, input int grp, input int il, input int ir, input int off,
                     input int fb, input int mx, input bit en, input int el, input int er);
    vec_t v;
    v = '{rst: rst, grp: grp, il: il, ir: ir, off: off, fb: fb, mx: mx, en: en, el: el, er: er};
    tab.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_l     = BITSIZE'(v.il);
    in_r     = BITSIZE'(v.ir);
    offset   = ADDRLEN'(v.off);
    feedback = 9'(v.fb);
    mix      = 9'(v.mx);
    enable   = v.en;
  endtask

  task automatic finish_frame(input int high_left);
    repeat (high_left) @(negedge bclk);
    lrclk = 1'b0;
    repeat (32) @(negedge bclk);
  endtask

  // Entered at the negedge right after the last reset edge
  task automatic clear_phase(input bit chk, input bit toggle);
    int cnt, ovc;
    reset = 1'b0;
    cnt = 0;
    ovc = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (toggle) lrclk = (cnt < 24) ? cnt[2] : 1'b0;
      @(negedge bclk);
      if (overrun) ovc++;
    end
    lrclk = 1'b0;
    check("clear completes", int'(busy), 0);
    if (chk) begin
      check("busy length", cnt, 32);
      check("overrun during clear", ovc, 0);
      repeat (4) @(negedge bclk);
      check("out_l after clear", sx(out_l), 0);
      check("out_r after clear", sx(out_r), 0);
    end
    model_reset();
  endtask

  task automatic do_reset(input bit chk, input bit toggle);
    @(negedge bclk);
    reset = 1'b1;
    lrclk = 1'b0;
    repeat (3) @(negedge bclk);
    if (chk) begin
      check("reset busy", int'(busy), 1);
      check("reset out_l", sx(out_l), 0);
      check("reset out_r", sx(out_r), 0);
      check("reset overrun", int'(overrun), 0);
    end
    clear_phase(chk, toggle);
  endtask

  task automatic run_frame(input vec_t v, input bit use_tab, input string tag);
    int el, er;
    model_frame(v.il, v.ir, v.off, v.fb, v.mx, v.en, el, er);
    if (use_tab) begin
      el = v.el;
      er = v.er;
    end
    @(negedge bclk);
    drive(v);
    lrclk = 1'b1;
    @(posedge bclk);
    repeat (6) @(posedge bclk);
    #1;
    check({tag, " out_l"}, sx(out_l), el);
    check({tag, " out_r"}, sx(out_r), er);
    finish_frame(26);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ex3[16];
    int el, er, ov;
    vec_t v;

    ex3 = '{1000, 0, 0, 1000, 0, 0, 500, 0, 0, 250, 0, 0, 125, 0, 0, 62};
    for (int f = 0; f < 8; f++)
      add(f == 0, 1, (f == 0) ? 1000 : 0, 0, 3, 0, 256, 1, (f == 0 || f == 3) ? 1000 : 0, 0);
    for (int f = 0; f < 16; f++)
      add(f == 0, 2, (f == 0) ? 1000 : 0, 0, 3, 128, 256, 1, ex3[f], 0);
    for (int f = 0; f < 6; f++)
      add(f == 0, 3, MAXV, MINV, 1, 256, 256, 1, MAXV, MINV);
    for (int f = 0; f < 4; f++)
      add(f == 0, 4, MINV, MAXV, 2, 300, 511, 1, MINV, MAXV);
    for (int f = 0; f < 5; f++)
      add(f == 0, 5, (f == 0) ? 1000 : 0, (f == 0) ? -1000 : 0, 2, 400, 300, 1,
          (f % 2 == 0) ? 1000 : 0, (f % 2 == 0) ? -1000 : 0);
    for (int f = 0; f < 17; f++)
      add(f == 0, 6, (f == 0) ? 1000 : 0, 0, 0, 0, 256, 1, (f == 0 || f == 16) ? 1000 : 0, 0);

    do_reset(1'b1, 1'b1);

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) do_reset(1'b0, 1'b0);
      run_frame(tab[i], 1'b1, $sformatf("tab g%0d #%0d", tab[i].grp, i));
    end

    // Bypass: old output holds through N+5, input appears at N+6
    model_frame(1234, -77, 0, 0, 256, 1'b0, el, er);
    @(negedge bclk);
    in_l = BITSIZE'(1234);
    in_r = BITSIZE'(-77);
    enable = 1'b0;
    lrclk = 1'b1;
    @(posedge bclk);
    repeat (5) @(posedge bclk);
    #1;
    check("bypass N+5 out_l", sx(out_l), 1000);
    check("bypass N+5 out_r", sx(out_r), 0);
    @(posedge bclk);
    #1;
    check("bypass N+6 out_l", sx(out_l), 1234);
    check("bypass N+6 out_r", sx(out_r), -77);
    finish_frame(26);

    // Second rise 3 cycles after the first is dropped with a 1-cycle overrun
    model_frame(700, -300, 5, 64, 200, 1'b1, el, er);
    @(negedge bclk);
    v = '{rst: 0, grp: 0, il: 700, ir: -300, off: 5, fb: 64, mx: 200, en: 1, el: 0, er: 0};
    drive(v);
    lrclk = 1'b1;
    @(posedge bclk);
    @(negedge bclk); lrclk = 1'b0;
    @(negedge bclk);
    @(negedge bclk); lrclk = 1'b1;
    ov = 0;
    for (int i = 3; i <= 12; i++) begin
      @(posedge bclk);
      #1;
      if (overrun) ov++;
      if (i == 4) check("overrun at N+4", int'(overrun), 1);
      if (i == 6) begin
        check("overrun frame out_l", sx(out_l), el);
        check("overrun frame out_r", sx(out_r), er);
      end
    end
    check("overrun pulse count", ov, 1);
    finish_frame(20);

    for (int i = 0; i < 3; i++) begin
      v = '{rst: 0, grp: 0, il: 100 * i - 50, ir: 300 - 70 * i, off: 5, fb: 64, mx: 200,
            en: 1, el: 0, er: 0};
      run_frame(v, 1'b0, "post-overrun");
    end

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      v.rst = 0;
      v.grp = 0;
      v.il  = int'($urandom_range(0, 65535)) - 32768;
      v.ir  = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 3) == 0) v.il = 0;
      v.off = int'($urandom_range(0, FRAMES - 1));
      v.fb  = int'($urandom_range(0, 300));
      v.mx  = int'($urandom_range(0, 300));
      v.en  = ($urandom_range(0, 3) != 0);
      v.el  = 0;
      v.er  = 0;
      run_frame(v, 1'b0, $sformatf("rand #%0d", i));
    end

    v = '{rst: 0, grp: 0, il: 500, ir: -500, off: 1, fb: 0, mx: 0, en: 0, el: 0, er: 0};
    run_frame(v, 1'b0, "pre-abort");

    // Reset sampled on the WR_R edge (N+5) aborts the frame
    @(negedge bclk);
    v = '{rst: 0, grp: 0, il: 321, ir: 654, off: 1, fb: 0, mx: 256, en: 1, el: 0, er: 0};
    drive(v);
    lrclk = 1'b1;
    @(posedge bclk);
    repeat (4) @(posedge bclk);
    @(negedge bclk);
    reset = 1'b1;
    lrclk = 1'b0;
    @(posedge bclk);
    #1;
    check("abort out_l", sx(out_l), 0);
    check("abort out_r", sx(out_r), 0);
    check("abort busy", int'(busy), 1);
    @(negedge bclk);
    clear_phase(1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      v = '{rst: 0, grp: 0, il: 2000 - 900 * i, ir: 450 * i, off: 2, fb: 200, mx: 256,
            en: 1, el: 0, er: 0};
      run_frame(v, 1'b0, "post-abort");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
